// File: rtl/ant_pkg.sv
// ant_pkg: shared constants, encodings and palette for the ant sprite engine
package ant_pkg;
  localparam int SPR_SZ = 16;
  localparam int ACT_W = 848;
  localparam int ACT_H = 480;
  localparam int MAX_X = ACT_W - SPR_SZ;
  localparam int MAX_Y = ACT_H - SPR_SZ;
  localparam logic [9:0] RST_X = 10'd416;
  localparam logic [8:0] RST_Y = 9'd232;
  localparam logic [7:0] PAL_GREY = 8'h40;
  localparam logic [7:0] PAL_BROWN = 8'h80;
  localparam logic [7:0] PAL_WHITE = 8'hFF;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
  typedef enum logic {ST_STILL, ST_WALK} state_e;
  function automatic logic [7:0] pal(input logic [1:0] idx);
    return idx == 2'd1 ? PAL_GREY : idx == 2'd2 ? PAL_BROWN : idx == 2'd3 ? PAL_WHITE : 8'h00;
  endfunction
endpackage

// File: rtl/ant_sprite_rom.sv
// ant_sprite_rom: synchronous 2-frame 16x16 2-bit sprite table (one-cycle read latency)
module ant_sprite_rom
  import ant_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame,
  input  logic [3:0] i_row,
  input  logic [3:0] i_col,
  output logic [1:0] o_idx
);
  logic [31:0] w_bits;
  // one row of the selected frame, column c occupies bits [2c+1:2c]
  always_comb begin
    case ({i_frame, i_row})
      5'h00: w_bits = 32'hC000_0001;
      5'h10: w_bits = 32'hC000_0002;
      5'h01, 5'h11: w_bits = 32'hC000_0000;
      5'h06, 5'h08, 5'h09, 5'h0A, 5'h16, 5'h18, 5'h19, 5'h1A: w_bits = 32'h0AAA_AAA0;
      5'h07, 5'h17: w_bits = 32'hFFAA_AAA0;
      5'h0C, 5'h1D: w_bits = 32'h4444_4444;
      5'h0D, 5'h1C: w_bits = 32'h1111_1111;
      default: w_bits = 32'h0000_0000;
    endcase
  end
  // registered lookup forms the second pixel stage
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_idx <= 2'd0;
    else o_idx <= w_bits[{i_col, 1'b0} +: 2];
endmodule

// File: rtl/ant_sprite_engine.sv
// ant_sprite_engine: 16x16 animated ant over a background; optional SPRITE_MIRROR_EN adds left/right facing
module ant_sprite_engine
  import ant_pkg::*;
#(
  parameter int H_START = 241,
  parameter int H_END = 1088,
  parameter int V_START = 38,
  parameter int V_END = 517,
  parameter int STEP = 2,
  parameter int ANIM_DIV = 8,
  parameter logic [23:0] BG_RGB = 24'h0000E1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_hcnt,
  input  logic [10:0] i_vcnt,
  input  logic [1:0]  i_dir,
  input  logic        i_move,
  output logic [7:0]  o_rgb_r,
  output logic [7:0]  o_rgb_g,
  output logic [7:0]  o_rgb_b,
  output logic        o_hit,
  output logic [9:0]  o_pos_x,
  output logic [8:0]  o_pos_y
);
  localparam int CW = $clog2(ANIM_DIV);
  logic [9:0] w_ax, w_dx, r_pos_x, w_xl, w_xr;
  logic [8:0] w_ay, w_dy, r_pos_y, w_yu, w_yd;
  logic [10:0] w_xp;
  logic [9:0] w_yp;
  logic [3:0] w_col, r_col1, r_row1;
  logic [1:0] w_idx;
  logic [7:0] w_px;
  logic [CW-1:0] r_cnt;
  logic w_act, w_in, w_evt, w_adv, w_clr, w_opq;
  logic r_act1, r_in1, r_act2, r_in2, r_anim;
  state_e r_state, w_next;
  assign w_ax = 10'(i_hcnt - 11'(H_START));
  assign w_ay = 9'(i_vcnt - 11'(V_START));
  assign w_dx = w_ax - r_pos_x;
  assign w_dy = w_ay - r_pos_y;
  assign w_act = i_hcnt >= 11'(H_START) && i_hcnt <= 11'(H_END) && i_vcnt >= 11'(V_START) && i_vcnt <= 11'(V_END);
  assign w_in = w_dx[9:4] == 6'd0 && w_dy[8:4] == 5'd0;
  assign w_evt = i_vcnt == 11'(V_END) && i_hcnt == 11'd0;
  assign o_pos_x = r_pos_x;
  assign o_pos_y = r_pos_y;
`ifdef SPRITE_MIRROR_EN
  logic r_face_l;
  assign w_col = r_face_l ? ~w_dx[3:0] : w_dx[3:0];
  // facing follows the last horizontal move; vertical moves keep it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_face_l <= 1'b0;
    else if (w_adv && i_dir == DIR_LEFT) r_face_l <= 1'b1;
    else if (w_adv && i_dir == DIR_RIGHT) r_face_l <= 1'b0;
`else
  assign w_col = w_dx[3:0];
`endif
  // stage 1: window/sprite hit flags and sprite-local coordinates
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_act1 <= 1'b0;
      r_in1 <= 1'b0;
      r_row1 <= 4'd0;
      r_col1 <= 4'd0;
    end else begin
      r_act1 <= w_act;
      r_in1 <= w_in;
      r_row1 <= w_dy[3:0];
      r_col1 <= w_col;
    end
  ant_sprite_rom u_rom (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_frame(r_anim),
    .i_row  (r_row1),
    .i_col  (r_col1),
    .o_idx  (w_idx)
  );
  // stage 2: flags travel alongside the ROM read
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_act2 <= 1'b0;
      r_in2 <= 1'b0;
    end else begin
      r_act2 <= r_act1;
      r_in2 <= r_in1;
    end
  // colour select from stage-2 registers: blank, sprite palette or background
  always_comb begin
    w_opq = r_in2 && w_idx != 2'd0;
    w_px = pal(w_idx);
    {o_rgb_r, o_rgb_g, o_rgb_b} = !r_act2 ? 24'd0 : w_opq ? {3{w_px}} : BG_RGB;
    o_hit = r_act2 && w_opq;
  end
  // walk state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= ST_STILL;
    else r_state <= w_next;
  // walk state advances only on the frame event
  always_comb w_next = w_evt ? (i_move ? ST_WALK : ST_STILL) : r_state;
  // per-event actions: advance while walking, clear on stopping
  always_comb begin
    w_adv = w_evt && w_next == ST_WALK;
    w_clr = w_evt && w_next == ST_STILL;
  end
  // animation frame toggles every ANIM_DIV walking events
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_anim <= 1'b0;
      r_cnt <= '0;
    end else if (w_clr) begin
      r_anim <= 1'b0;
      r_cnt <= '0;
    end else if (w_adv) begin
      r_anim <= r_cnt == CW'(ANIM_DIV - 1) ? ~r_anim : r_anim;
      r_cnt <= r_cnt == CW'(ANIM_DIV - 1) ? '0 : r_cnt + 1'b1;
    end
  // saturating candidate positions for each direction
  always_comb begin
    w_xp = {1'b0, r_pos_x} + 11'(STEP);
    w_xr = w_xp > 11'(MAX_X) ? 10'(MAX_X) : w_xp[9:0];
    w_xl = r_pos_x < 10'(STEP) ? 10'd0 : r_pos_x - 10'(STEP);
    w_yp = {1'b0, r_pos_y} + 10'(STEP);
    w_yd = w_yp > 10'(MAX_Y) ? 9'(MAX_Y) : w_yp[8:0];
    w_yu = r_pos_y < 9'(STEP) ? 9'd0 : r_pos_y - 9'(STEP);
  end
  // position moves once per frame event, visible from the next frame
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pos_x <= RST_X;
      r_pos_y <= RST_Y;
    end else if (w_adv) begin
      r_pos_x <= i_dir == DIR_RIGHT ? w_xr : i_dir == DIR_LEFT ? w_xl : r_pos_x;
      r_pos_y <= i_dir == DIR_DOWN ? w_yd : i_dir == DIR_UP ? w_yu : r_pos_y;
    end
endmodule

// File: tb/tb_ant_sprite_engine.sv
// tb_ant_sprite_engine: directed scoreboard bench for ant_sprite_engine (honours SPRITE_MIRROR_EN)
module tb_ant_sprite_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] hcnt = 11'd0;
  logic [10:0] vcnt = 11'd0;
  logic [1:0] dir = 2'd0;
  logic move = 1'b0;
  logic [7:0] rr, gg, bb;
  logic hit;
  logic [9:0] px;
  logic [8:0] py;
  int checks = 0;
  int failures = 0;
  logic [24:0] exp_q[$];
  string tag_q[$];
  logic [1:0] vsh = 2'd0;
  int mx = 416;
  int my = 232;
  int mc = 0;
  logic ma = 1'b0;
  logic fl = 1'b0;
  localparam logic [24:0] BG = {24'h0000E1, 1'b0};

  always #5 clk = ~clk;

  ant_sprite_engine dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_hcnt (hcnt),
    .i_vcnt (vcnt),
    .i_dir  (dir),
    .i_move (move),
    .o_rgb_r(rr),
    .o_rgb_g(gg),
    .o_rgb_b(bb),
    .o_hit  (hit),
    .o_pos_x(px),
    .o_pos_y(py)
  );

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", t, got, want);
    end
  endtask

  function automatic logic [24:0] sp(input logic [1:0] idx);
    logic [7:0] c;
    c = idx == 2'd1 ? 8'h40 : idx == 2'd2 ? 8'h80 : 8'hFF;
    return idx == 2'd0 ? BG : {c, c, c, 1'b1};
  endfunction

  function automatic logic [1:0] corner_idx(input logic col15);
    logic m;
`ifdef SPRITE_MIRROR_EN
    m = fl;
`else
    m = 1'b0;
`endif
    return (col15 ^ m) ? 2'd3 : (ma ? 2'd2 : 2'd1);
  endfunction

  task automatic cyc(input int h, input int v, input logic val, input logic [24:0] e, input string t);
    logic [24:0] pe;
    string pt;
    @(negedge clk);
    if (vsh[1]) begin
      pe = exp_q.pop_front();
      pt = tag_q.pop_front();
      chk(pt, {7'd0, rr, gg, bb, hit}, {7'd0, pe});
    end
    hcnt = 11'(h);
    vcnt = 11'(v);
    vsh = {vsh[0], val};
    if (val) begin
      exp_q.push_back(e);
      tag_q.push_back(t);
    end
  endtask

  task automatic flush();
    repeat (3) cyc(0, 0, 1'b0, 25'd0, "");
  endtask

  task automatic mstep();
    if (move) begin
      case (dir)
        2'd0: my = my < 2 ? 0 : my - 2;
        2'd1: my = my + 2 > 464 ? 464 : my + 2;
        2'd2: mx = mx < 2 ? 0 : mx - 2;
        default: mx = mx + 2 > 832 ? 832 : mx + 2;
      endcase
      if (dir == 2'd2) fl = 1'b1;
      else if (dir == 2'd3) fl = 1'b0;
      if (mc == 7) begin
        mc = 0;
        ma = ~ma;
      end else mc++;
    end else begin
      mc = 0;
      ma = 1'b0;
    end
  endtask

  task automatic ev();
    int ox, oy;
    ox = mx;
    oy = my;
    cyc(0, 517, 1'b0, 25'd0, "");
    mstep();
    #1 chk("evhold", {13'd0, px, py}, {13'd0, 10'(ox), 9'(oy)});
    cyc(0, 0, 1'b0, 25'd0, "");
    chk("evpos", {13'd0, px, py}, {13'd0, 10'(mx), 9'(my)});
  endtask

  task automatic pix_corner(input string t);
    cyc(241 + mx, 38 + my, 1'b1, sp(corner_idx(1'b0)), t);
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rgb", {8'd0, rr, gg, bb}, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_pos", {13'd0, px, py}, {13'd0, 10'd416, 9'd232});
    rst_n = 1'b1;
    cyc(657, 270, 1'b1, sp(2'd1), "px00");
    cyc(658, 270, 1'b1, BG, "px01_transp");
    cyc(700, 100, 1'b1, BG, "bg");
    cyc(100, 270, 1'b1, 25'd0, "hblank");
    cyc(672, 277, 1'b1, sp(2'd3), "eye");
    cyc(662, 278, 1'b1, sp(2'd2), "body");
    cyc(673, 270, 1'b1, BG, "xedge");
    cyc(656, 270, 1'b1, BG, "xlow");
    cyc(657, 286, 1'b1, BG, "yedge");
    cyc(1088, 300, 1'b1, BG, "hend");
    cyc(1089, 300, 1'b1, 25'd0, "hpast");
    cyc(241, 38, 1'b1, BG, "origin");
    cyc(240, 38, 1'b1, 25'd0, "hpre");
    cyc(241, 37, 1'b1, 25'd0, "vpre");
    cyc(241, 517, 1'b1, BG, "vend");
    cyc(241, 518, 1'b1, 25'd0, "vpast");
    flush();
    dir = 2'd3;
    move = 1'b1;
    repeat (3) ev();
    chk("move3", {13'd0, px, py}, {13'd0, 10'd422, 9'd232});
    pix_corner("anim3");
    flush();
    cyc(0, 300, 1'b0, 25'd0, "");
    dir = 2'd0;
    move = 1'b0;
    cyc(0, 300, 1'b0, 25'd0, "");
    dir = 2'd2;
    cyc(0, 516, 1'b0, 25'd0, "");
    move = 1'b1;
    dir = 2'd1;
    cyc(5, 517, 1'b0, 25'd0, "");
    move = 1'b0;
    cyc(0, 518, 1'b0, 25'd0, "");
    chk("nochg_pos", {13'd0, px, py}, {13'd0, 10'd422, 9'd232});
    dir = 2'd3;
    move = 1'b1;
    repeat (4) ev();
    pix_corner("anim7");
    flush();
    ev();
    pix_corner("anim8");
    flush();
    move = 1'b0;
    ev();
    pix_corner("still");
    flush();
    move = 1'b1;
    repeat (7) ev();
    pix_corner("re7");
    flush();
    ev();
    pix_corner("re8");
    flush();
    while (mx < 830) ev();
    chk("x830", {22'd0, px}, 32'd830);
    ev();
    chk("x832", {22'd0, px}, 32'd832);
    ev();
    chk("x832_sat", {22'd0, px}, 32'd832);
    dir = 2'd0;
    while (my > 0) ev();
    ev();
    chk("y0_sat", {23'd0, py}, 32'd0);
    dir = 2'd2;
    while (mx > 0) ev();
    ev();
    chk("x0_sat", {22'd0, px}, 32'd0);
    pix_corner("mir_col0");
    cyc(256, 38, 1'b1, sp(corner_idx(1'b1)), "mir_col15");
    flush();
    dir = 2'd1;
    while (my < 464) ev();
    ev();
    chk("y464_sat", {23'd0, py}, 32'd464);
    repeat (3) cyc(241 + mx, 38 + my, 1'b0, 25'd0, "");
    chk("prehit", {31'd0, hit}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", {8'd0, rr, gg, bb}, 32'd0);
    chk("mid_rst_hit", {31'd0, hit}, 32'd0);
    chk("mid_rst_pos", {13'd0, px, py}, {13'd0, 10'd416, 9'd232});
    mx = 416;
    my = 232;
    mc = 0;
    ma = 1'b0;
    fl = 1'b0;
    move = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pix_corner("refill");
    flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
